// File: rtl/shim_pkg.sv
// Shared types and helpers for the shim input arbiter.
package shim_pkg;

    // Upper bound on requesters; the pick helper works on a fixed-width request vector.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MD   = 2'd1,
        DATA = 2'd2
    } state_e;

    // Round-robin first-set search: scan from last+1 upward, wrapping modulo n.
    // Returns 0 when nothing is requested; callers only use it when a request exists.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input int unsigned        n
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % n);
            if (k <= n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shim_arbiter.sv
// Round-robin packet arbiter in front of shim: each grant carries one metadata beat
// followed by one complete data packet, so sources never interleave.
module shim_arbiter
    import shim_pkg::*;
#(
    parameter int unsigned DW   = 512,
    parameter int unsigned NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [NREQ*DW-1:0]    AXIS_REQ_MD_TDATA,
    input  logic [NREQ-1:0]       AXIS_REQ_MD_TVALID,
    output logic [NREQ-1:0]       AXIS_REQ_MD_TREADY,

    input  logic [NREQ*DW-1:0]    AXIS_REQ_TDATA,
    input  logic [NREQ*DW/8-1:0]  AXIS_REQ_TKEEP,
    input  logic [NREQ-1:0]       AXIS_REQ_TLAST,
    input  logic [NREQ-1:0]       AXIS_REQ_TVALID,
    output logic [NREQ-1:0]       AXIS_REQ_TREADY,

    output logic [DW-1:0]         AXIS_OUT_MD_TDATA,
    output logic                  AXIS_OUT_MD_TVALID,
    input  logic                  AXIS_OUT_MD_TREADY,

    output logic [DW-1:0]         AXIS_OUT_TDATA,
    output logic [DW/8-1:0]       AXIS_OUT_TKEEP,
    output logic                  AXIS_OUT_TLAST,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY,

    output logic [NREQ-1:0]       GRANT,
    output logic                  BUSY
);

    localparam int unsigned KW = DW / 8;

    state_e           r_state;
    logic [NREQ-1:0]  r_grant;
    logic [IDX_W-1:0] r_last;

    logic [MAX_REQ-1:0] w_md_req;
    logic [IDX_W-1:0]   w_pick;

    logic [DW-1:0]      w_md_tdata;
    logic               w_md_tvalid;
    logic [DW-1:0]      w_tdata;
    logic [KW-1:0]      w_tkeep;
    logic               w_tlast;
    logic               w_tvalid;
    logic               w_in_md;
    logic               w_in_data;

    // Widen the MD valids to the fixed width the pick helper expects.
    always_comb begin
        w_md_req = '0;
        w_md_req[NREQ-1:0] = AXIS_REQ_MD_TVALID;
    end

    assign w_pick    = rr_pick(w_md_req, r_last, NREQ);
    assign w_in_md   = (r_state == MD);
    assign w_in_data = (r_state == DATA);

    // One-hot select of the owner's streams; grant is zero in IDLE so nothing is selected.
    always_comb begin
        w_md_tdata  = '0;
        w_md_tvalid = 1'b0;
        w_tdata     = '0;
        w_tkeep     = '0;
        w_tlast     = 1'b0;
        w_tvalid    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_md_tdata  = AXIS_REQ_MD_TDATA[i*DW +: DW];
                w_md_tvalid = AXIS_REQ_MD_TVALID[i];
                w_tdata     = AXIS_REQ_TDATA[i*DW +: DW];
                w_tkeep     = AXIS_REQ_TKEEP[i*KW +: KW];
                w_tlast     = AXIS_REQ_TLAST[i];
                w_tvalid    = AXIS_REQ_TVALID[i];
            end
        end
    end

    // Passthrough gated by phase; payload forced to zero whenever its valid is low.
    always_comb begin
        AXIS_OUT_MD_TVALID = w_in_md && w_md_tvalid;
        AXIS_OUT_MD_TDATA  = AXIS_OUT_MD_TVALID ? w_md_tdata : '0;
        AXIS_OUT_TVALID    = w_in_data && w_tvalid;
        AXIS_OUT_TDATA     = AXIS_OUT_TVALID ? w_tdata : '0;
        AXIS_OUT_TKEEP     = AXIS_OUT_TVALID ? w_tkeep : '0;
        AXIS_OUT_TLAST     = AXIS_OUT_TVALID && w_tlast;
        AXIS_REQ_MD_TREADY = w_in_md   ? (r_grant & {NREQ{AXIS_OUT_MD_TREADY}}) : '0;
        AXIS_REQ_TREADY    = w_in_data ? (r_grant & {NREQ{AXIS_OUT_TREADY}})    : '0;
    end

    // Arbitration FSM: pick on MD valid in IDLE, hold the owner until its TLAST beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NREQ - 1);
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|AXIS_REQ_MD_TVALID) begin
                        r_state <= MD;
                        r_grant <= NREQ'(1) << w_pick;
                        r_last  <= w_pick;
                    end
                end
                MD: begin
                    if (AXIS_OUT_MD_TVALID && AXIS_OUT_MD_TREADY) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (AXIS_OUT_TVALID && AXIS_OUT_TREADY && AXIS_OUT_TLAST) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign GRANT = r_grant;
    assign BUSY  = (r_state != IDLE);

endmodule

// File: tb/tb_shim_arbiter.sv
// Randomized bench for shim_arbiter: behavioural sources and a packet-level
// round-robin reference model, checked every cycle.
module tb_shim_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned KW   = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ*DW-1:0] md_tdata;
    logic [NREQ-1:0]    md_tvalid;
    logic [NREQ-1:0]    md_tready;
    logic [NREQ*DW-1:0] tdata;
    logic [NREQ*KW-1:0] tkeep;
    logic [NREQ-1:0]    tlast;
    logic [NREQ-1:0]    tvalid;
    logic [NREQ-1:0]    tready;
    logic [DW-1:0]      o_md_tdata;
    logic               o_md_tvalid;
    logic               o_md_tready;
    logic [DW-1:0]      o_tdata;
    logic [KW-1:0]      o_tkeep;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;
    logic [NREQ-1:0]    grant;
    logic               busy;

    shim_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
        .clk                (clk),
        .reset              (reset),
        .AXIS_REQ_MD_TDATA  (md_tdata),
        .AXIS_REQ_MD_TVALID (md_tvalid),
        .AXIS_REQ_MD_TREADY (md_tready),
        .AXIS_REQ_TDATA     (tdata),
        .AXIS_REQ_TKEEP     (tkeep),
        .AXIS_REQ_TLAST     (tlast),
        .AXIS_REQ_TVALID    (tvalid),
        .AXIS_REQ_TREADY    (tready),
        .AXIS_OUT_MD_TDATA  (o_md_tdata),
        .AXIS_OUT_MD_TVALID (o_md_tvalid),
        .AXIS_OUT_MD_TREADY (o_md_tready),
        .AXIS_OUT_TDATA     (o_tdata),
        .AXIS_OUT_TKEEP     (o_tkeep),
        .AXIS_OUT_TLAST     (o_tlast),
        .AXIS_OUT_TVALID    (o_tvalid),
        .AXIS_OUT_TREADY    (o_tready),
        .GRANT              (grant),
        .BUSY               (busy)
    );

    // Source state per requester.
    bit            act [NREQ];
    bit            mdv [NREQ];
    logic [DW-1:0] mdd [NREQ];
    int            nbeat [NREQ];
    int            bidx [NREQ];
    bit            dv [NREQ];
    logic [DW-1:0] dd [NREQ];
    logic [KW-1:0] dk [NREQ];
    bit            dl [NREQ];
    bit            en [NREQ];
    bit            mdh [NREQ];
    bit            dh [NREQ];
    bit            allow_start;
    bit            toggle_rdy;
    bit            all_rdy;

    // Reference model: phase 0 idle, 1 metadata, 2 data.
    int m_phase, m_owner, m_last;
    int n_phase, n_owner, n_last;
    int m_pkts, s_pkts;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NREQ; r++) begin
            md_tdata[r*DW +: DW] = mdd[r];
            md_tvalid[r]         = mdv[r];
            tdata[r*DW +: DW]    = dd[r];
            tkeep[r*KW +: KW]    = dk[r];
            tlast[r]             = dl[r];
            tvalid[r]            = dv[r];
        end
    endtask

    task automatic start_pkt(input int r);
        act[r]   = 1'b1;
        mdv[r]   = 1'b1;
        mdd[r]   = $urandom;
        nbeat[r] = $urandom_range(4, 1);
        bidx[r]  = 0;
    endtask

    task automatic clear_sources();
        for (int r = 0; r < NREQ; r++) begin
            act[r] = 1'b0;
            mdv[r] = 1'b0;
            dv[r]  = 1'b0;
            dl[r]  = 1'b0;
            mdd[r] = '0;
            dd[r]  = '0;
            dk[r]  = '0;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg, emdr, edr;
        bit              emv, edv, elast;
        logic [DW-1:0]   emd, ed;
        logic [KW-1:0]   ek;
        eg = '0; emdr = '0; edr = '0;
        emv = 0; edv = 0; elast = 0; emd = '0; ed = '0; ek = '0;
        if (m_phase != 0) eg[m_owner] = 1'b1;
        if (m_phase == 1) begin
            emv = mdv[m_owner];
            emd = emv ? mdd[m_owner] : '0;
            emdr[m_owner] = o_md_tready;
        end
        if (m_phase == 2) begin
            edv   = dv[m_owner];
            ed    = edv ? dd[m_owner] : '0;
            ek    = edv ? dk[m_owner] : '0;
            elast = edv && dl[m_owner];
            edr[m_owner] = o_tready;
        end
        check_eq("grant",     64'(grant),       64'(eg));
        check_eq("busy",      64'(busy),        64'(m_phase != 0));
        check_eq("md_valid",  64'(o_md_tvalid), 64'(emv));
        check_eq("md_data",   64'(o_md_tdata),  64'(emd));
        check_eq("md_ready",  64'(md_tready),   64'(emdr));
        check_eq("d_valid",   64'(o_tvalid),    64'(edv));
        check_eq("d_data",    64'(o_tdata),     64'(ed));
        check_eq("d_keep",    64'(o_tkeep),     64'(ek));
        check_eq("d_last",    64'(o_tlast),     64'(elast));
        check_eq("d_ready",   64'(tready),      64'(edr));
    endtask

    // Round-robin rule applied at packet granularity.
    task automatic model_next();
        n_phase = m_phase; n_owner = m_owner; n_last = m_last;
        case (m_phase)
            0: begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (n_phase == 0 && mdv[idx]) begin
                        n_phase = 1; n_owner = idx; n_last = idx;
                    end
                end
            end
            1: if (mdv[m_owner] && o_md_tready) n_phase = 2;
            default: if (dv[m_owner] && o_tready && dl[m_owner]) begin
                n_phase = 0;
                m_pkts++;
            end
        endcase
    endtask

    task automatic src_update();
        for (int r = 0; r < NREQ; r++) begin
            if (mdv[r] && mdh[r]) mdv[r] = 1'b0;
            if (dv[r] && dh[r]) begin
                bidx[r]++;
                if (dl[r]) begin
                    act[r] = 1'b0;
                    s_pkts++;
                end
                dv[r] = 1'b0;
            end
            if (!mdv[r]) mdd[r] = $urandom;
            if (!act[r] && en[r] && allow_start && $urandom_range(3) == 0) start_pkt(r);
            if (act[r] && !dv[r] && bidx[r] < nbeat[r] && $urandom_range(2) != 0) begin
                dv[r] = 1'b1;
                dd[r] = $urandom;
                dk[r] = KW'($urandom);
                dl[r] = (bidx[r] == nbeat[r] - 1);
            end
            if (!dv[r]) begin
                dd[r] = $urandom;
                dk[r] = KW'($urandom);
                dl[r] = 1'($urandom_range(1));
            end
        end
        if (all_rdy) begin
            o_md_tready = 1'b1;
            o_tready    = 1'b1;
        end else if (toggle_rdy) begin
            o_md_tready = 1'b1;
            o_tready    = ~o_tready;
        end else begin
            o_md_tready = ($urandom_range(3) != 0);
            o_tready    = ($urandom_range(3) != 0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        for (int r = 0; r < NREQ; r++) begin
            mdh[r] = mdv[r] && md_tready[r];
            dh[r]  = dv[r] && tready[r];
        end
        model_next();
        @(posedge clk);
        #1;
        m_phase = n_phase; m_owner = n_owner; m_last = n_last;
        src_update();
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_grant",    64'(grant),       64'd0);
        check_eq("rst_busy",     64'(busy),        64'd0);
        check_eq("rst_md_valid", 64'(o_md_tvalid), 64'd0);
        check_eq("rst_md_data",  64'(o_md_tdata),  64'd0);
        check_eq("rst_d_valid",  64'(o_tvalid),    64'd0);
        check_eq("rst_d_data",   64'(o_tdata),     64'd0);
        check_eq("rst_d_keep",   64'(o_tkeep),     64'd0);
        check_eq("rst_d_last",   64'(o_tlast),     64'd0);
        check_eq("rst_md_ready", 64'(md_tready),   64'd0);
        check_eq("rst_d_ready",  64'(tready),      64'd0);
        clear_sources();
        drive();
        m_phase = 0; m_owner = 0; m_last = NREQ - 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        allow_start = 1'b0; toggle_rdy = 1'b0; all_rdy = 1'b0;
        o_md_tready = 1'b1; o_tready = 1'b1;
        m_pkts = 0; s_pkts = 0;
        for (int r = 0; r < NREQ; r++) begin
            en[r] = 1'b1; mdh[r] = 1'b0; dh[r] = 1'b0; nbeat[r] = 1; bidx[r] = 0;
        end
        clear_sources();
        drive();
        do_reset();

        // First grant after reset goes to requester 0 even when 1 asks too.
        run(1);
        start_pkt(0); start_pkt(1); drive();
        run(2);
        check_eq("first_grant_r0", 64'(grant), 64'(4'b0001));

        // Broad random traffic, all requesters, random backpressure.
        allow_start = 1'b1;
        run(1500);

        // Alternating OUT_TREADY during data.
        toggle_rdy = 1'b1;
        run(400);
        toggle_rdy = 1'b0;

        // Requesters 1 and 3 only, starting from last=3: 1 wins, then 3.
        do_reset();
        for (int r = 0; r < NREQ; r++) en[r] = (r == 1 || r == 3);
        allow_start = 1'b0;
        run(1);
        start_pkt(1); start_pkt(3); drive();
        run(2);
        check_eq("nreq4_first", 64'(grant), 64'(4'b0010));
        allow_start = 1'b1;
        run(600);

        // Drain, then data valid without metadata must not get a grant.
        allow_start = 1'b0; all_rdy = 1'b1;
        run(100);
        dv[1] = 1'b1; dd[1] = 32'hDEAD_BEEF; dk[1] = 4'hF; dl[1] = 1'b1; drive();
        run(10);
        check_eq("data_only_grant", 64'(grant), 64'd0);
        check_eq("data_only_ready", 64'(tready), 64'd0);
        dv[1] = 1'b0; drive();
        all_rdy = 1'b0;

        // Reset mid-packet, then requester 0 must win first.
        for (int r = 0; r < NREQ; r++) en[r] = 1'b1;
        allow_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            if (m_phase == 2 && bidx[m_owner] >= 1) found = 1'b1;
        end
        check_eq("reset_mid_found", 64'(found), 64'd1);
        do_reset();
        allow_start = 1'b0;
        run(1);
        start_pkt(2); start_pkt(0); drive();
        run(2);
        check_eq("post_reset_r0", 64'(grant), 64'(4'b0001));
        allow_start = 1'b1;
        run(600);

        // Final drain: every started packet must complete exactly once.
        allow_start = 1'b0; all_rdy = 1'b1;
        run(150);
        for (int r = 0; r < NREQ; r++) check_eq($sformatf("drain_r%0d", r), 64'(act[r]), 64'd0);
        check_eq("pkt_count", 64'(s_pkts), 64'(m_pkts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shim_arbiter.md
# shim_arbiter

Round-robin packet arbiter that shares the single shim input (metadata stream plus data stream) among NREQ pingponger-side requesters. Each grant covers exactly one metadata beat followed by one full data packet, ending on TLAST, so metadata and payload are never interleaved across sources. Sits directly upstream of shim; its outputs connect to shim's AXIS_IN_MD_* and AXIS_IN_* ports.

## Interface
- DW, 512, data width of MD and data streams (bits); multiple of 8
- NREQ, 2, number of requesters; 2..8
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- AXIS_REQ_MD_TDATA  in  NREQ*DW  per-requester metadata; requester i at [i*DW +: DW]
- AXIS_REQ_MD_TVALID  in  NREQ  per-requester MD valid
- AXIS_REQ_MD_TREADY  out  NREQ  per-requester MD ready
- AXIS_REQ_TDATA  in  NREQ*DW  per-requester packet data
- AXIS_REQ_TKEEP  in  NREQ*DW/8  per-requester byte keep
- AXIS_REQ_TLAST  in  NREQ  per-requester end of packet
- AXIS_REQ_TVALID  in  NREQ  per-requester data valid
- AXIS_REQ_TREADY  out  NREQ  per-requester data ready
- AXIS_OUT_MD_TDATA / TVALID / TREADY  out/out/in  DW/1/1  metadata to shim
- AXIS_OUT_TDATA / TKEEP / TLAST / TVALID  out  DW/DW/8/1/1  data to shim
- AXIS_OUT_TREADY  in  1  data ready from shim
- GRANT  out  NREQ  one-hot index of the current owner; 0 when idle
- BUSY  out  1  high in MD and DATA states

## Operation
- FSM states: IDLE, MD, DATA. Registers: state, grant (one-hot), last (index of the most recent winner).
- IDLE: if any MD_TVALID is high, pick the first requester with MD_TVALID set, scanning from last+1 upward and wrapping modulo NREQ. Register it as grant, set last to it, and move to MD. Data TVALID is ignored for arbitration.
- MD: pass the granted requester's MD stream through combinationally (TDATA, TVALID downstream; TREADY upstream). On the OUT_MD handshake, move to DATA.
- DATA: pass the granted data stream through combinationally (TDATA, TKEEP, TLAST, TVALID, TREADY). On a handshake with TLAST=1, move to IDLE and clear grant.
- Non-granted requesters see TREADY=0 on both of their streams. In IDLE, all upstream TREADY=0 and all OUT TVALID=0.
- The data stream is never forwarded in MD state, and MD is never forwarded in DATA state.
- A zero-length packet does not exist: every grant carries at least one data beat.
- Muxed TDATA, TKEEP and TLAST outputs are don't-care while their TVALID is 0; drive them to 0 for determinism.

## Timing
- Reset values: state=IDLE, grant=0, last=NREQ-1 (so requester 0 wins first). All OUT TVALID, TDATA, TKEEP, TLAST = 0. All REQ TREADY = 0. GRANT=0, BUSY=0.
- Arbitration latency: MD_TVALID seen in IDLE at cycle n; the MD beat is presented on OUT at cycle n+1.
- Datapath latency is 0 cycles; there are no pipeline registers.
- After the TLAST handshake at cycle m, the arbiter is in IDLE at m+1 and a new MD beat can appear at m+2. Worst-case bubble is 2 cycles per packet.
- Backpressure: TVALID and payload from the source must hold stable until TREADY; the arbiter adds no constraint beyond passthrough.
- Simultaneous requests: only one winner per IDLE cycle; losers keep waiting and their TVALID stays high.
- Reset asserted mid-packet: everything returns to reset values immediately (asynchronously). A partially sent packet is truncated; recovering it is the upstream's responsibility.

## Structure
- Single module; no sub-module is needed beyond an optional rr_pick function (round-robin first-set search) placed in shim_pkg.
- shim_pkg holds the state enumeration (IDLE=2'd0, MD=2'd1, DATA=2'd2) and the rr_pick function.

## Test plan
- Single requester 0, MD=0xA5, 3-beat packet with TLAST on beat 3, OUT always ready -> OUT_MD beat at cycle n+1, data beats at n+2..n+4, GRANT=01 throughout, IDLE at n+5.
- Both requesters continuously offer packets -> grant order 0,1,0,1; no beat from requester 1 appears during requester 0's grant.
- OUT_TREADY toggled 1,0,1,0 during DATA -> every beat is delivered exactly once, and the upstream TREADY mirrors OUT_TREADY for the owner only.
- Requester 1 holds data TVALID but MD_TVALID=0 -> no grant is issued and REQ TREADY stays 0.
- Reset pulsed during beat 2 of a 4-beat packet -> all outputs reset within the same cycle; the next grant goes to requester 0.
- NREQ=4, requesters 1 and 3 active with last=3 -> requester 1 wins, then requester 3.
